// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters are enabled by defining PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 155,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;

  logic accept;
  logic load_main;

  // in_ready comes straight from a flop, so out_ready never reaches upstream combinationally.
  assign in_ready  = ~s_valid_q;
  assign accept    = in_valid & in_ready;
  assign load_main = ~m_valid_q | out_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;

    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_ctrl_d  = '0;
    end else if (load_main) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = accept;
        if (accept) begin
          s_ctrl_d = in_ctrl;
          s_data_d = in_data;
        end
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = in_ctrl;
        m_data_d  = in_data;
      end else begin
        // Bubble: control is squashed, data keeps its last value.
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = in_ctrl;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, so out_data reads zero right after reset.
    if (rst) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_ctrl  = m_valid_q ? m_ctrl_q : '0;
  assign out_data  = m_data_q;

`ifdef PIPE_STAGE_REG_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Saturating counters; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (m_valid_q && !out_ready && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (!m_valid_q && !(&bubble_cnt_q))
        bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: pass-through, skid, flush, reset, bubble, counters.
module tb_pipe_stage_reg;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 155;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Data payload derived from the control byte, touching both ends of the field.
  function automatic logic [DATA_W-1:0] mk_data(input logic [7:0] c);
    logic [DATA_W-1:0] d;
    d = '0;
    d[15:0]       = {8'hD0, c};
    d[DATA_W-1]   = c[0];
    d[DATA_W-2]   = ~c[0];
    return d;
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = mk_data(c);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
    check("rst_out_ctrl",  DATA_W'(out_ctrl),  DATA_W'(0));
    check("rst_out_data",  out_data,           DATA_W'(0));
    check("rst_in_ready",  DATA_W'(in_ready),  DATA_W'(1));

    // Pass-through: one beat per cycle, each visible the cycle after acceptance.
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h11 + 8'(i));
      @(negedge clk);
      check("pt_valid", DATA_W'(out_valid), DATA_W'(1));
      check("pt_ctrl",  DATA_W'(out_ctrl),  DATA_W'(8'h11 + 8'(i)));
      check("pt_data",  out_data,           mk_data(8'h11 + 8'(i)));
      check("pt_ready", DATA_W'(in_ready),  DATA_W'(1));
    end

    // Bubble: control squashed, data holds the last beat.
    drive(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bub_valid", DATA_W'(out_valid), DATA_W'(0));
      check("bub_ctrl",  DATA_W'(out_ctrl),  DATA_W'(0));
      check("bub_data",  out_data,           mk_data(8'h15));
    end

    // Stall / skid: A1 presented, A2 caught in skid, A3 held upstream.
    drive(1'b1, 8'hA1);
    @(negedge clk);
    check("sk_a1_ctrl", DATA_W'(out_ctrl), DATA_W'(8'hA1));
    out_ready = 1'b0;
    drive(1'b1, 8'hA2);
    @(negedge clk);
    check("sk_hold_ctrl",  DATA_W'(out_ctrl), DATA_W'(8'hA1));
    check("sk_hold_data",  out_data,          mk_data(8'hA1));
    check("sk_full_ready", DATA_W'(in_ready), DATA_W'(0));
    drive(1'b1, 8'hA3);
    @(negedge clk);
    check("sk_stable_data", out_data,          mk_data(8'hA1));
    check("sk_still_full",  DATA_W'(in_ready), DATA_W'(0));
    out_ready = 1'b1;
    @(negedge clk);
    check("sk_a2_ctrl",  DATA_W'(out_ctrl), DATA_W'(8'hA2));
    check("sk_a2_ready", DATA_W'(in_ready), DATA_W'(1));
    @(negedge clk);
    check("sk_a3_ctrl", DATA_W'(out_ctrl), DATA_W'(8'hA3));
    check("sk_a3_data", out_data,          mk_data(8'hA3));
    drive(1'b0, 8'h00);
    @(negedge clk);
    check("sk_empty", DATA_W'(out_valid), DATA_W'(0));

    // Flush while full: main 0x33, skid 0x34, 0x35 offered alongside the flush.
    out_ready = 1'b0;
    drive(1'b1, 8'h33);
    @(negedge clk);
    drive(1'b1, 8'h34);
    @(negedge clk);
    check("fl_pre_ctrl",  DATA_W'(out_ctrl), DATA_W'(8'h33));
    check("fl_pre_ready", DATA_W'(in_ready), DATA_W'(0));
    flush = 1'b1;
    drive(1'b1, 8'h35);
    @(negedge clk);
    check("fl_valid", DATA_W'(out_valid), DATA_W'(0));
    check("fl_ctrl",  DATA_W'(out_ctrl),  DATA_W'(0));
    check("fl_ready", DATA_W'(in_ready),  DATA_W'(1));
    check("fl_data",  out_data,           mk_data(8'h33));
    // Flush with a beat actually accepted in the same cycle: it is discarded.
    out_ready = 1'b1;
    drive(1'b1, 8'h36);
    @(negedge clk);
    check("fl_acc_valid", DATA_W'(out_valid), DATA_W'(0));
    flush = 1'b0;
    drive(1'b0, 8'h00);
    @(negedge clk);
    check("fl_no_leak", DATA_W'(out_valid), DATA_W'(0));

    // Reset beats flush and traffic with both registers holding beats.
    out_ready = 1'b0;
    drive(1'b1, 8'h41);
    @(negedge clk);
    drive(1'b1, 8'h42);
    @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 8'h43);
    @(negedge clk);
    check("rp_valid", DATA_W'(out_valid), DATA_W'(0));
    check("rp_ctrl",  DATA_W'(out_ctrl),  DATA_W'(0));
    check("rp_data",  out_data,           DATA_W'(0));
    check("rp_ready", DATA_W'(in_ready),  DATA_W'(1));
    check("rp_stall0",  DATA_W'(stall_cnt),  DATA_W'(0));
    check("rp_bubble0", DATA_W'(bubble_cnt), DATA_W'(0));

    // Counter run: 1 empty cycle after reset, 4 stalls, 1 drain, 3 empty, 1 flush (empty).
    rst = 1'b0; flush = 1'b0;
    drive(1'b1, 8'h51);
    @(negedge clk);
    drive(1'b0, 8'h00);
    repeat (4) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("pc_drained_ctrl", DATA_W'(out_ctrl), DATA_W'(0));
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
`ifdef PIPE_STAGE_REG_PERF_EN
    check("pc_stall",  DATA_W'(stall_cnt),  DATA_W'(4));
    check("pc_bubble", DATA_W'(bubble_cnt), DATA_W'(5));
`else
    check("pc_stall_tied",  DATA_W'(stall_cnt),  DATA_W'(0));
    check("pc_bubble_tied", DATA_W'(bubble_cnt), DATA_W'(0));
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline boundary register, generalising the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Splits each beat into a control field and a data field.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush, and bubble insertion.
- Sits between any two core stages; the hazard unit drives `flush` and back-pressure via `out_ready`.

Parameters:
- CTRL_W, 8, width of control field (e.g. 2 write-back + 2 memory + 4 execute bits); zeroed on bubble/flush.
- DATA_W, 155, width of data field (operands, immediates, register indices, branch info); never zeroed except by reset.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash all held beats (branch mispredict / exception).
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  beat presented downstream.
- out_ready  in  1  downstream accepts beat this cycle.
- out_ctrl  out  CTRL_W  control field; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data field; holds last value when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0 (optional).
- bubble_cnt  out  CNT_W  cycles with out_valid=0 (optional).

Behaviour:
- Storage:
  - Main register (m_valid, m_ctrl, m_data) drives the outputs.
  - Skid register (s_valid, s_ctrl, s_data) catches one beat when downstream stalls.
- Handshake:
  - in_ready = !s_valid, taken directly from a register (no combinational path from out_ready).
  - Accept = in_valid & in_ready.
  - Drain = m_valid & out_ready.
- Outputs: out_valid = m_valid; out_ctrl = m_valid ? m_ctrl : 0; out_data = m_data.
- Latency: beat accepted in cycle N appears at the outputs in cycle N+1 when the stage is empty. Sustained throughput is 1 beat/cycle while out_ready=1.
- Per-edge update, in priority order:
  1. rst=1: m_valid=0, s_valid=0; m_ctrl, s_ctrl, m_data, s_data = 0. Counters = 0. Outputs after the edge: out_valid=0, out_ctrl=0, out_data=0, in_ready=1. rst overrides flush and all traffic.
  2. flush=1: m_valid=0, s_valid=0, m_ctrl=0, s_ctrl=0; data registers unchanged. A beat accepted in the same cycle is discarded. in_ready=1 next cycle.
  3. Main register empty, or draining:
     - s_valid=1: main loads from skid; skid takes the accepted beat if any, else s_valid=0.
     - s_valid=0: main loads the accepted beat, or m_valid=0 if none.
  4. Main register full and not draining:
     - Accept with s_valid=0: beat goes to skid, s_valid=1.
     - Accept cannot occur with s_valid=1 (in_ready=0).
- Ordering: beats leave in acceptance order; none lost or duplicated except by flush/rst.
- Boundaries:
  - Full (m_valid=1, s_valid=1): in_ready=0. When out_ready rises, skid moves to main in 1 cycle, and in_ready=1 the following cycle.
  - Empty: out_valid=0, out_ctrl forced 0, so downstream sees a NOP bubble.
  - Simultaneous accept and drain with an empty skid: main replaced, no bubble.
  - out_data is stable while out_valid=1 and out_ready=0.
- Reset mid-stream: all held beats dropped; no beat presented the cycle after reset.

Optional Feature:
- Macro PIPE_STAGE_REG_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0.
  - Both saturate at all-ones, clear on rst, and are unaffected by flush.
- Undefined: stall_cnt and bubble_cnt tied to 0; no counter flops synthesised; ports retained.

Test Plan:
- Pass-through: rst 2 cycles, then 5 beats ctrl=0x11..0x15 with out_ready=1 → out_valid rises 1 cycle after the first accept; outputs 0x11..0x15 on consecutive cycles; in_ready stays 1.
- Stall/skid: stream ctrl=0xA1,0xA2,0xA3 and drop out_ready after 0xA1 is presented.
  - Expect 0xA2 captured in skid, then in_ready=0.
  - 0xA3 held upstream.
  - On out_ready=1, expected order is 0xA1,0xA2,0xA3 with no loss or duplication.
- Flush while full: main=0x33, skid=0x34, flush=1 with in_valid=1 ctrl=0x35 → next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x35 never appears.
- Reset priority: rst=1 and flush=1 with beats held → out_valid=0, out_ctrl=0, out_data=0, in_ready=1 next cycle.
- Bubble: in_valid=0 for 3 cycles with out_ready=1 → out_ctrl=0 during the bubble; out_data retains its last value.
- Perf (PIPE_STAGE_REG_PERF_EN defined): 4 stall cycles and 3 empty cycles after reset → stall_cnt=4, bubble_cnt=3 plus the empty cycles following reset; a flush does not clear either counter.
